// File: rtl/kw_reset_pkg.sv
// Shared types and helpers for the multi-channel reset sequencer.
package kw_reset_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_STRETCH,
      ST_RELEASE,
      ST_DONE
   } kw_reset_state_e;

   // Wide enough to hold the larger of the stretch and gap reload values.
   function automatic int cnt_width(input int stretch, input int gap);
      int m;
      m = (stretch > gap) ? stretch : gap;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/kw_reset_seq_timer.sv
// Loadable down-counter with zero flag; stops at zero and is reloaded for every sequencing step.
module kw_reset_seq_timer #(
   parameter int W = 4
) (
   input  logic         clock,
   input  logic         i_reset_n,
   input  logic         i_load,
   input  logic [W-1:0] i_value,
   output logic         o_zero
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (i_load) begin
         count_d = i_value;
      end else if (count_q != '0) begin
         count_d = count_q - W'(1);
      end
   end

   always_ff @(posedge clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign o_zero = (count_q == '0);

endmodule

// File: rtl/kw_reset_sequencer.sv
// Multi-channel AASD reset sequencer with stretch, ordered release and soft reset.
// Define KW_RESET_SEQ_ACK_EN to add the i_ack port gating each channel-to-channel gap.
module kw_reset_sequencer
   import kw_reset_pkg::*;
#(
   parameter int STAGES   = 4,
   parameter int CHANNELS = 3,
   parameter int STRETCH  = 8,
   parameter int GAP      = 2
) (
   input  logic                clock,
   input  logic                i_reset_n,
   input  logic                testmode,
   input  logic                i_sw_reset,
`ifdef KW_RESET_SEQ_ACK_EN
   input  logic [CHANNELS-1:0] i_ack,
`endif
   output logic [CHANNELS-1:0] o_reset_n,
   output logic                o_done
);

   // The state register acts as the last synchronizer stage, so the chain holds STAGES-1 flops.
   localparam int SYNC_W = STAGES - 1;
   localparam int CNT_W  = cnt_width(STRETCH, GAP);
   localparam int IDX_W  = $clog2(CHANNELS + 1);

   typedef logic [CNT_W-1:0] cnt_t;
   typedef logic [IDX_W-1:0] idx_t;

   localparam cnt_t STRETCH_LOAD = cnt_t'(STRETCH - 1);
   localparam cnt_t GAP_LOAD     = cnt_t'(GAP - 1);
   localparam idx_t LAST_IDX     = idx_t'(CHANNELS - 1);

   logic [SYNC_W-1:0]   sync_q, sync_d;
   kw_reset_state_e     state_q, state_d;
   idx_t                idx_q, idx_d;
   logic [CHANNELS-1:0] rst_q, rst_d;
   logic                done_q, done_d;
   logic                chain_ok;
   logic                cnt_load;
   cnt_t                cnt_value;
   logic                cnt_zero;

   assign chain_ok = sync_q[SYNC_W-1];
   assign sync_d   = SYNC_W'({sync_q, 1'b1});

   kw_reset_seq_timer #(.W(CNT_W)) u_timer (
      .clock     (clock),
      .i_reset_n (i_reset_n),
      .i_load    (cnt_load),
      .i_value   (cnt_value),
      .o_zero    (cnt_zero)
   );

`ifdef KW_RESET_SEQ_ACK_EN
   logic ack_wait_q, ack_wait_d;
   logic ack_sel;

   always_comb begin
      ack_sel = 1'b0;
      for (int k = 0; k < CHANNELS; k++) begin
         if (idx_t'(k + 1) == idx_q) ack_sel = i_ack[k];
      end
   end
`endif

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      rst_d     = rst_q;
      cnt_load  = 1'b0;
      cnt_value = '0;
`ifdef KW_RESET_SEQ_ACK_EN
      ack_wait_d = ack_wait_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (chain_ok && !i_sw_reset) begin
               cnt_load  = 1'b1;
               cnt_value = STRETCH_LOAD;
               state_d   = ST_STRETCH;
            end
         end
         ST_STRETCH: begin
            if (cnt_zero) begin
               rst_d[0]  = 1'b1;
               idx_d     = idx_t'(1);
               cnt_load  = 1'b1;
               cnt_value = GAP_LOAD;
`ifdef KW_RESET_SEQ_ACK_EN
               ack_wait_d = 1'b1;
               state_d    = ST_RELEASE;
`else
               state_d    = (CHANNELS == 1) ? ST_DONE : ST_RELEASE;
`endif
            end
         end
         ST_RELEASE: begin
`ifdef KW_RESET_SEQ_ACK_EN
            // The gap for the next step only starts counting once the previous channel acks.
            if (ack_wait_q) begin
               if (ack_sel) begin
                  cnt_load   = 1'b1;
                  cnt_value  = GAP_LOAD;
                  ack_wait_d = 1'b0;
               end
            end else if (cnt_zero) begin
               if (idx_q == idx_t'(CHANNELS)) begin
                  state_d = ST_DONE;
               end else begin
                  for (int k = 0; k < CHANNELS; k++) begin
                     if (idx_t'(k) == idx_q) rst_d[k] = 1'b1;
                  end
                  idx_d      = idx_q + idx_t'(1);
                  ack_wait_d = 1'b1;
               end
            end
`else
            if (cnt_zero) begin
               for (int k = 0; k < CHANNELS; k++) begin
                  if (idx_t'(k) == idx_q) rst_d[k] = 1'b1;
               end
               idx_d     = idx_q + idx_t'(1);
               cnt_load  = 1'b1;
               cnt_value = GAP_LOAD;
               if (idx_q == LAST_IDX) state_d = ST_DONE;
            end
`endif
         end
         default: begin
            state_d = ST_DONE;
         end
      endcase
      if (i_sw_reset) begin
         state_d = ST_IDLE;
         idx_d   = '0;
         rst_d   = '0;
`ifdef KW_RESET_SEQ_ACK_EN
         ack_wait_d = 1'b0;
`endif
      end
      done_d = (state_q == ST_DONE) && !i_sw_reset;
   end

   always_ff @(posedge clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         sync_q  <= '0;
         state_q <= ST_IDLE;
         idx_q   <= '0;
         rst_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         state_q <= state_d;
         idx_q   <= idx_d;
         rst_q   <= rst_d;
         done_q  <= done_d;
      end
   end

`ifdef KW_RESET_SEQ_ACK_EN
   always_ff @(posedge clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         ack_wait_q <= 1'b0;
      end else begin
         ack_wait_q <= ack_wait_d;
      end
   end
`endif

   assign o_reset_n = testmode ? {CHANNELS{i_reset_n}} : rst_q;
   assign o_done    = testmode ? i_reset_n : done_q;

endmodule
